metaframe_deframer: RTL and testbench

//  Interlaken RX lane framing-layer stage fed by the descrambler's locked, descrambled 64-bit words and 2-bit headers.
//  - Tracks the Meta Frame.
//  - Strips Sync, Scrambler-State, Skip and Diagnostic words.
//  - Checks the per-frame CRC-32C.
//  - Extracts lane/link status bits.
//  - Forwards payload (data and burst/idle control words) to the lane-deskew stage.

---
 rtl/ilkn_pkg.sv | 46 ++++
 rtl/metaframe_deframer_if.sv | 55 +++++
 rtl/metaframe_deframer_crc32c_d64.sv | 35 +++
 rtl/metaframe_deframer.sv | 230 +++++++++++++++++++++++
 tb/tb_metaframe_deframer.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ilkn_pkg.sv
// ----------------------------------------------------------------------------
// ilkn_pkg
//   Shared Interlaken lane-layer definitions used by the descrambler and the
//   Meta Frame deframer:
//     - 2-bit framing header codes
//     - 6-bit block-type codes found in DATA[63:58] of framing control words
//     - CRC-32C polynomial and seed
//     - default Sync word
//     - deframer FSM state encoding (also exported for debug observation)
//   No ports; import with `import ilkn_pkg::*;`.
// ----------------------------------------------------------------------------
package ilkn_pkg;

    // Framing header codes. 00 and 11 are illegal on the wire.
    localparam logic [1:0] HDR_DATA = 2'b01;
    localparam logic [1:0] HDR_CTRL = 2'b10;

    // Block types carried in DATA[63:58] of framing-layer control words.
    localparam logic [5:0] BT_SYNC  = 6'b011110;
    localparam logic [5:0] BT_SCRAM = 6'b001010;
    localparam logic [5:0] BT_SKIP  = 6'b000111;
    localparam logic [5:0] BT_DIAG  = 6'b011001;

    // CRC-32C, processed MSB first, not reflected.
    localparam logic [31:0] CRC32C_POLY = 32'h1EDC6F41;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;

    // Sync word shared with the descrambler.
    localparam logic [63:0] SYNC_WORD_DEFAULT = 64'h78f678f678f678f6;

    // Deframer FSM. CHECK is the "frame just ended, Sync must follow" state;
    // the CRC comparison itself happens in the Diag word's own cycle.
    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_FRAME = 2'd1,
        ST_CHECK = 2'd2
    } deframer_state_e;

    // True when the word is a framing control word of the given block type.
    function automatic logic block_is(input logic [1:0]  hdr,
                                      input logic [63:0] data,
                                      input logic [5:0]  bt);
        return (hdr == HDR_CTRL) && (data[63:58] == bt);
    endfunction

endpackage

// File: rtl/metaframe_deframer_if.sv
// ----------------------------------------------------------------------------
// metaframe_deframer_if
//   Bundles the deframer's lane input and payload/status output signals.
//
//   Handshake: there is no backpressure. DATA_IN/HEADER_IN are consumed on
//   every clock where DATA_VALID_IN=1; a low DATA_VALID_IN is a pause and
//   nothing advances. DATA_OUT/CTRL_OUT are meaningful only in a cycle where
//   VALID_OUT=1, and each such cycle carries exactly one payload word.
//
//   Modports:
//     master - upstream side: drives the lane inputs, observes the outputs
//     slave  - the deframer: consumes the lane inputs, drives the outputs
//   state_dbg exposes the deframer FSM state for observation only.
// ----------------------------------------------------------------------------
interface metaframe_deframer_if #(
    parameter int CNT_WIDTH = 16
);
    import ilkn_pkg::*;

    // Lane input (descrambled, locked words)
    logic [63:0]          DATA_IN;
    logic [1:0]           HEADER_IN;
    logic                 LOCKED_IN;
    logic                 DATA_VALID_IN;

    // Payload output towards lane deskew
    logic [63:0]          DATA_OUT;
    logic                 CTRL_OUT;
    logic                 VALID_OUT;

    // Alignment, error and status reporting
    logic                 ALIGNED;
    logic                 CRC_ERROR;
    logic                 FRAMING_ERROR;
    logic                 LANE_STATUS;
    logic                 LINK_STATUS;
    logic [CNT_WIDTH-1:0] CRC_ERR_CNT;
    logic [CNT_WIDTH-1:0] FRM_ERR_CNT;

    // Debug view of the FSM
    deframer_state_e      state_dbg;

    modport master (
        output DATA_IN, HEADER_IN, LOCKED_IN, DATA_VALID_IN,
        input  DATA_OUT, CTRL_OUT, VALID_OUT, ALIGNED, CRC_ERROR, FRAMING_ERROR,
        input  LANE_STATUS, LINK_STATUS, CRC_ERR_CNT, FRM_ERR_CNT, state_dbg
    );

    modport slave (
        input  DATA_IN, HEADER_IN, LOCKED_IN, DATA_VALID_IN,
        output DATA_OUT, CTRL_OUT, VALID_OUT, ALIGNED, CRC_ERROR, FRAMING_ERROR,
        output LANE_STATUS, LINK_STATUS, CRC_ERR_CNT, FRM_ERR_CNT, state_dbg
    );

endinterface

// File: rtl/metaframe_deframer_crc32c_d64.sv
// ----------------------------------------------------------------------------
// crc32c_d64
//   Combinational one-word CRC-32C update: advances a 32-bit CRC register by
//   64 data bits, bit 63 first, polynomial 0x1EDC6F41, non-reflected.
//   Seeding, masking and final inversion are left to the caller.
//
//   Ports:
//     crc_i   in  32  current CRC register
//     data_i  in  64  word to absorb (bit 63 enters first)
//     crc_o   out 32  CRC register after the word
// ----------------------------------------------------------------------------
module crc32c_d64
    import ilkn_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [63:0] data_i,
    output logic [31:0] crc_o
);

    logic [31:0] c;

    // Bit-serial formulation unrolled by synthesis into the XOR network.
    always_comb begin
        c = crc_i;
        for (int i = 63; i >= 0; i--) begin
            if (c[31] ^ data_i[i]) begin
                c = {c[30:0], 1'b0} ^ CRC32C_POLY;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        crc_o = c;
    end

endmodule

// File: rtl/metaframe_deframer.sv
// ----------------------------------------------------------------------------
// metaframe_deframer
//   Interlaken RX lane framing stage. Locks onto the Meta Frame, strips the
//   Sync / Scrambler-State / Skip / Diagnostic words, checks the per-frame
//   CRC-32C against the Diag word, captures lane/link status from good
//   frames and forwards payload words (data and burst/idle control words)
//   one clock after they arrive.
//
//   Parameters:
//     META_FRAME_LEN  words per Meta Frame incl. the 4 framing words (>= 5)
//     SYNC_WORD       expected Sync word
//     CNT_WIDTH       width of the saturating error counters
//
//   Ports:
//     USER_CLK        in  clock
//     SYSTEM_RESET_N  in  asynchronous active-low reset
//     bus             slave modport of metaframe_deframer_if: lane input,
//                     payload output, ALIGNED, error pulses, status bits,
//                     saturating error counters and FSM debug state
// ----------------------------------------------------------------------------
module metaframe_deframer
    import ilkn_pkg::*;
#(
    parameter int          META_FRAME_LEN = 16,
    parameter logic [63:0] SYNC_WORD      = SYNC_WORD_DEFAULT,
    parameter int          CNT_WIDTH      = 16
) (
    input  logic                 USER_CLK,
    input  logic                 SYSTEM_RESET_N,
    metaframe_deframer_if.slave  bus
);

    localparam int                POS_W    = $clog2(META_FRAME_LEN);
    localparam logic [POS_W-1:0]  POS_SCR  = POS_W'(1);
    localparam logic [POS_W-1:0]  POS_LAST = POS_W'(META_FRAME_LEN - 1);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    deframer_state_e      state_q,         state_d;
    logic [POS_W-1:0]     pos_q,           pos_d;
    logic [31:0]          crc_q,           crc_d;
    logic [63:0]          data_out_q,      data_out_d;
    logic                 ctrl_out_q,      ctrl_out_d;
    logic                 valid_out_q,     valid_out_d;
    logic                 aligned_q,       aligned_d;
    logic                 crc_error_q,     crc_error_d;
    logic                 framing_error_q, framing_error_d;
    logic                 lane_status_q,   lane_status_d;
    logic                 link_status_q,   link_status_d;
    logic [CNT_WIDTH-1:0] crc_err_cnt_q,   crc_err_cnt_d;
    logic [CNT_WIDTH-1:0] frm_err_cnt_q,   frm_err_cnt_d;

    // ------------------------------------------------------------------
    // Input classification
    // ------------------------------------------------------------------
    logic hdr_bad;
    logic is_sync;
    logic at_last;

    assign hdr_bad = (bus.HEADER_IN == 2'b00) || (bus.HEADER_IN == 2'b11);
    assign is_sync = (bus.HEADER_IN == HDR_CTRL) && (bus.DATA_IN == SYNC_WORD);
    assign at_last = (state_q == ST_FRAME) && (pos_q == POS_LAST);

    // ------------------------------------------------------------------
    // CRC datapath. A single update unit serves every cycle: inside a frame
    // it extends the running CRC; in HUNT/CHECK it seeds a new CRC from the
    // candidate Sync word. The Diag CRC field is absorbed as zeros.
    // ------------------------------------------------------------------
    logic [31:0] crc_seed;
    logic [63:0] crc_word;
    logic [31:0] crc_next;
    logic [31:0] crc_final;

    assign crc_seed  = (state_q == ST_FRAME) ? crc_q : CRC_INIT;
    assign crc_word  = at_last ? {bus.DATA_IN[63:32], 32'h0} : bus.DATA_IN;
    assign crc_final = ~crc_next;

    crc32c_d64 u_crc (
        .crc_i  (crc_seed),
        .data_i (crc_word),
        .crc_o  (crc_next)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        pos_d           = pos_q;
        crc_d           = crc_q;
        data_out_d      = data_out_q;
        ctrl_out_d      = ctrl_out_q;
        valid_out_d     = 1'b0;
        aligned_d       = aligned_q;
        crc_error_d     = 1'b0;
        framing_error_d = 1'b0;
        lane_status_d   = lane_status_q;
        link_status_d   = link_status_q;

        if (!bus.LOCKED_IN) begin
            // Lost lock: drop alignment regardless of DATA_VALID_IN.
            state_d   = ST_HUNT;
            pos_d     = '0;
            crc_d     = CRC_INIT;
            aligned_d = 1'b0;
        end else if (bus.DATA_VALID_IN) begin
            if (hdr_bad) begin
                framing_error_d = 1'b1;
            end

            case (state_q)
                ST_HUNT: begin
                    aligned_d = 1'b0;
                    if (is_sync) begin
                        state_d = ST_FRAME;
                        pos_d   = POS_SCR;
                        crc_d   = crc_next;
                    end
                end

                ST_FRAME: begin
                    crc_d = crc_next;
                    pos_d = pos_q + POS_W'(1);
                    if (pos_q == POS_SCR) begin
                        if (!block_is(bus.HEADER_IN, bus.DATA_IN, BT_SCRAM)) begin
                            framing_error_d = 1'b1;
                        end
                    end else if (pos_q == POS_LAST) begin
                        // End of frame: the CRC check is folded into this cycle.
                        if (!block_is(bus.HEADER_IN, bus.DATA_IN, BT_DIAG)) begin
                            framing_error_d = 1'b1;
                        end
                        if (crc_final != bus.DATA_IN[31:0]) begin
                            crc_error_d = 1'b1;
                        end else begin
                            lane_status_d = bus.DATA_IN[33];
                            link_status_d = bus.DATA_IN[32];
                        end
                        aligned_d = 1'b1;
                        state_d   = ST_CHECK;
                        pos_d     = '0;
                    end else begin
                        // Payload region: drop Skip words and illegal headers.
                        if (!hdr_bad && !block_is(bus.HEADER_IN, bus.DATA_IN, BT_SKIP)) begin
                            valid_out_d = 1'b1;
                            data_out_d  = bus.DATA_IN;
                            ctrl_out_d  = (bus.HEADER_IN == HDR_CTRL);
                        end
                    end
                end

                ST_CHECK: begin
                    if (is_sync) begin
                        state_d = ST_FRAME;
                        pos_d   = POS_SCR;
                        crc_d   = crc_next;
                    end else begin
                        framing_error_d = 1'b1;
                        state_d         = ST_HUNT;
                        aligned_d       = 1'b0;
                    end
                end

                default: begin
                    state_d   = ST_HUNT;
                    aligned_d = 1'b0;
                end
            endcase
        end

        // Counters saturate and never wrap.
        crc_err_cnt_d = crc_err_cnt_q;
        if (crc_error_d && (crc_err_cnt_q != '1)) begin
            crc_err_cnt_d = crc_err_cnt_q + CNT_WIDTH'(1);
        end
        frm_err_cnt_d = frm_err_cnt_q;
        if (framing_error_d && (frm_err_cnt_q != '1)) begin
            frm_err_cnt_d = frm_err_cnt_q + CNT_WIDTH'(1);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
        if (!SYSTEM_RESET_N) begin
            state_q         <= ST_HUNT;
            pos_q           <= '0;
            crc_q           <= CRC_INIT;
            data_out_q      <= '0;
            ctrl_out_q      <= 1'b0;
            valid_out_q     <= 1'b0;
            aligned_q       <= 1'b0;
            crc_error_q     <= 1'b0;
            framing_error_q <= 1'b0;
            lane_status_q   <= 1'b0;
            link_status_q   <= 1'b0;
            crc_err_cnt_q   <= '0;
            frm_err_cnt_q   <= '0;
        end else begin
            state_q         <= state_d;
            pos_q           <= pos_d;
            crc_q           <= crc_d;
            data_out_q      <= data_out_d;
            ctrl_out_q      <= ctrl_out_d;
            valid_out_q     <= valid_out_d;
            aligned_q       <= aligned_d;
            crc_error_q     <= crc_error_d;
            framing_error_q <= framing_error_d;
            lane_status_q   <= lane_status_d;
            link_status_q   <= link_status_d;
            crc_err_cnt_q   <= crc_err_cnt_d;
            frm_err_cnt_q   <= frm_err_cnt_d;
        end
    end

    assign bus.DATA_OUT      = data_out_q;
    assign bus.CTRL_OUT      = ctrl_out_q;
    assign bus.VALID_OUT     = valid_out_q;
    assign bus.ALIGNED       = aligned_q;
    assign bus.CRC_ERROR     = crc_error_q;
    assign bus.FRAMING_ERROR = framing_error_q;
    assign bus.LANE_STATUS   = lane_status_q;
    assign bus.LINK_STATUS   = link_status_q;
    assign bus.CRC_ERR_CNT   = crc_err_cnt_q;
    assign bus.FRM_ERR_CNT   = frm_err_cnt_q;
    assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_metaframe_deframer.sv
// ----------------------------------------------------------------------------
// tb_metaframe_deframer
//   Directed bench for metaframe_deframer. dut uses the default 16-word
//   frame and 16-bit counters; dut2 uses a 5-word frame and 4-bit counters
//   so counter saturation is reachable in a short run.
// ----------------------------------------------------------------------------
module tb_metaframe_deframer;
  import ilkn_pkg::*;

  localparam logic [63:0] SYNC = 64'h78f678f678f678f6;
  localparam logic [63:0] SCR  = 64'h2800000000000000;
  localparam logic [63:0] SKIP = 64'h1E00000000000000;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  int   cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  metaframe_deframer_if #(.CNT_WIDTH(16)) bus ();
  metaframe_deframer_if #(.CNT_WIDTH(4))  bus2 ();

  metaframe_deframer #(.META_FRAME_LEN(16), .SYNC_WORD(SYNC), .CNT_WIDTH(16)) dut (
    .USER_CLK       (clk),
    .SYSTEM_RESET_N (rst_n),
    .bus            (bus)
  );

  metaframe_deframer #(.META_FRAME_LEN(5), .SYNC_WORD(SYNC), .CNT_WIDTH(4)) dut2 (
    .USER_CLK       (clk),
    .SYSTEM_RESET_N (rst_n),
    .bus            (bus2)
  );

  // ---------------- scoreboard state ----------------
  logic [64:0] exp_q[$];   // {ctrl, data}
  int          exp_t_q[$]; // cycle the word was driven
  int          n_chk;
  int          n_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference CRC-32C, MSB first, one bit at a time.
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [63:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 64; i++) begin
      fb = r[31] ^ d[63-i];
      r  = r << 1;
      if (fb) r = r ^ 32'h1EDC6F41;
    end
    return r;
  endfunction

  // ---------------- monitor ----------------
  logic [64:0] got;
  logic [64:0] want;
  int          want_t;

  always @(negedge clk) begin
    if (bus.VALID_OUT === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid_out", 64'(bus.VALID_OUT), 64'd0);
      end else begin
        want   = exp_q.pop_front();
        want_t = exp_t_q.pop_front();
        got    = {bus.CTRL_OUT, bus.DATA_OUT};
        check("payload_data", got[63:0], want[63:0]);
        check("payload_ctrl", 64'(got[64]), 64'(want[64]));
        check("payload_latency", 64'(cyc), 64'(want_t + 1));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send_word(input logic [1:0] h, input logic [63:0] d);
    bus.HEADER_IN     = h;
    bus.DATA_IN       = d;
    bus.DATA_VALID_IN = 1'b1;
    @(negedge clk);
    bus.DATA_VALID_IN = 1'b0;
  endtask

  task automatic send_payload(input logic [1:0] h, input logic [63:0] d);
    exp_q.push_back({(h == 2'b10), d});
    exp_t_q.push_back(cyc);
    send_word(h, d);
  endtask

  task automatic idle(input int n);
    bus.DATA_VALID_IN = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // 16-word frame: Sync, ScrState, Skip, 12 payload words base+1..base+12,
  // Diag. skip2/ctrl_pos replace a payload slot; flip corrupts one bit of a
  // slot after the CRC is computed; pause inserts an idle after every word.
  task automatic send_frame(input logic [63:0] base, input int skip2, input int flip,
                            input int ctrl_pos, input logic [1:0] st, input bit pause);
    logic [63:0] w[16];
    logic [1:0]  h[16];
    logic [31:0] c;
    w[0] = SYNC; h[0] = 2'b10;
    w[1] = SCR;  h[1] = 2'b10;
    w[2] = SKIP; h[2] = 2'b10;
    for (int i = 3; i <= 14; i++) begin
      w[i] = base + 64'(i - 2);
      h[i] = 2'b01;
    end
    if (ctrl_pos != 0) begin
      w[ctrl_pos] = 64'h8000_0000_0000_0000 | 64'(ctrl_pos);
      h[ctrl_pos] = 2'b10;
    end
    if (skip2 != 0) begin
      w[skip2] = SKIP;
      h[skip2] = 2'b10;
    end
    w[15] = {6'b011001, 24'h0, st, 32'h0};
    h[15] = 2'b10;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < 16; i++) c = crc_upd(c, w[i]);
    w[15][31:0] = ~c;
    if (flip != 0) w[flip][0] = ~w[flip][0];
    for (int i = 0; i < 16; i++) begin
      if (i >= 2 && i <= 14 && w[i] != SKIP) send_payload(h[i], w[i]);
      else send_word(h[i], w[i]);
      if (pause) idle(1);
    end
  endtask

  task automatic send_word2(input logic [1:0] h, input logic [63:0] d);
    bus2.HEADER_IN     = h;
    bus2.DATA_IN       = d;
    bus2.DATA_VALID_IN = 1'b1;
    @(negedge clk);
    bus2.DATA_VALID_IN = 1'b0;
  endtask

  // 5-word frame for dut2: Sync, ScrState, Skip, one data word, Diag.
  task automatic send_frame5(input logic [63:0] d, input bit bad_crc);
    logic [63:0] w[5];
    logic [31:0] c;
    w[0] = SYNC;
    w[1] = SCR;
    w[2] = SKIP;
    w[3] = d;
    w[4] = {6'b011001, 24'h0, 2'b11, 32'h0};
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) c = crc_upd(c, w[i]);
    w[4][31:0] = bad_crc ? (~c ^ 32'h1) : ~c;
    send_word2(2'b10, w[0]);
    send_word2(2'b10, w[1]);
    send_word2(2'b10, w[2]);
    send_word2(2'b01, w[3]);
    send_word2(2'b10, w[4]);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    n_chk = 0;
    n_err = 0;
    cyc   = 0;
    rst_n = 1'b0;
    bus.DATA_IN = '0;  bus.HEADER_IN = 2'b01;  bus.LOCKED_IN = 1'b0;  bus.DATA_VALID_IN = 1'b0;
    bus2.DATA_IN = '0; bus2.HEADER_IN = 2'b01; bus2.LOCKED_IN = 1'b0; bus2.DATA_VALID_IN = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_valid_out", 64'(bus.VALID_OUT), 64'd0);
    check("rst_aligned", 64'(bus.ALIGNED), 64'd0);
    check("rst_data_out", bus.DATA_OUT, 64'd0);
    check("rst_crc_cnt", 64'(bus.CRC_ERR_CNT), 64'd0);
    check("rst_state", 64'(bus.state_dbg), 64'(ST_HUNT));

    rst_n = 1'b1;
    bus.LOCKED_IN = 1'b1;
    @(negedge clk);

    // 1: three clean frames
    send_frame(64'h0, 0, 0, 0, 2'b11, 1'b0);
    check("t1_aligned_f1", 64'(bus.ALIGNED), 64'd1);
    check("t1_lane_f1", 64'(bus.LANE_STATUS), 64'd1);
    check("t1_link_f1", 64'(bus.LINK_STATUS), 64'd1);
    send_frame(64'h0, 0, 0, 0, 2'b11, 1'b0);
    send_frame(64'h0, 0, 0, 0, 2'b11, 1'b0);
    check("t1_crc_cnt", 64'(bus.CRC_ERR_CNT), 64'd0);
    check("t1_frm_cnt", 64'(bus.FRM_ERR_CNT), 64'd0);

    // 2: extra Skip at pos 4
    send_frame(64'h10, 4, 0, 0, 2'b11, 1'b0);
    check("t2_crc_err", 64'(bus.CRC_ERROR), 64'd0);
    check("t2_frm_cnt", 64'(bus.FRM_ERR_CNT), 64'd0);

    // 3: corrupted data word, Diag status bits would clear both if loaded
    send_frame(64'h20, 0, 7, 0, 2'b00, 1'b0);
    check("t3_crc_pulse", 64'(bus.CRC_ERROR), 64'd1);
    check("t3_crc_cnt", 64'(bus.CRC_ERR_CNT), 64'd1);
    check("t3_lane_kept", 64'(bus.LANE_STATUS), 64'd1);
    check("t3_link_kept", 64'(bus.LINK_STATUS), 64'd1);

    // 4: status 01 with good CRC, plus a control payload word
    send_frame(64'h30, 0, 0, 10, 2'b01, 1'b0);
    check("t4_crc_err", 64'(bus.CRC_ERROR), 64'd0);
    check("t4_lane", 64'(bus.LANE_STATUS), 64'd0);
    check("t4_link", 64'(bus.LINK_STATUS), 64'd1);
    check("t4_crc_cnt", 64'(bus.CRC_ERR_CNT), 64'd1);

    // 5: data word where Sync is due
    send_word(2'b01, 64'hDEAD);
    check("t5_frm_pulse", 64'(bus.FRAMING_ERROR), 64'd1);
    check("t5_aligned", 64'(bus.ALIGNED), 64'd0);
    check("t5_state", 64'(bus.state_dbg), 64'(ST_HUNT));
    check("t5_frm_cnt", 64'(bus.FRM_ERR_CNT), 64'd1);
    send_word(2'b01, 64'hBEEF);
    check("t5_hunt_no_err", 64'(bus.FRAMING_ERROR), 64'd0);
    send_frame(64'h100, 0, 0, 0, 2'b11, 1'b0);
    check("t5_realigned", 64'(bus.ALIGNED), 64'd1);
    check("t5_lane", 64'(bus.LANE_STATUS), 64'd1);

    // 6a: illegal header mid-frame, then loss of lock
    send_word(2'b10, SYNC);
    send_word(2'b10, SCR);
    send_word(2'b10, SKIP);
    send_payload(2'b01, 64'h201);
    send_payload(2'b01, 64'h202);
    send_word(2'b11, 64'h203);
    check("t6_hdr_frm_pulse", 64'(bus.FRAMING_ERROR), 64'd1);
    check("t6_hdr_not_fwd", 64'(bus.VALID_OUT), 64'd0);
    check("t6_frm_cnt", 64'(bus.FRM_ERR_CNT), 64'd2);
    bus.LOCKED_IN = 1'b0;
    send_word(2'b01, 64'h204);
    check("t6_unlock_aligned", 64'(bus.ALIGNED), 64'd0);
    check("t6_unlock_valid", 64'(bus.VALID_OUT), 64'd0);
    check("t6_unlock_state", 64'(bus.state_dbg), 64'(ST_HUNT));
    check("t6_unlock_crc_cnt", 64'(bus.CRC_ERR_CNT), 64'd1);
    bus.LOCKED_IN = 1'b1;
    send_word(2'b01, 64'h205);
    send_word(2'b01, 64'h206);

    // 6b: frame with DATA_VALID_IN pauses
    send_frame(64'h300, 0, 0, 0, 2'b10, 1'b1);
    check("t6_pause_aligned", 64'(bus.ALIGNED), 64'd1);
    check("t6_pause_lane", 64'(bus.LANE_STATUS), 64'd1);
    check("t6_pause_link", 64'(bus.LINK_STATUS), 64'd0);
    check("t6_pause_frm_cnt", 64'(bus.FRM_ERR_CNT), 64'd2);

    // 6c: reset mid-frame
    send_word(2'b10, SYNC);
    send_word(2'b10, SCR);
    send_word(2'b10, SKIP);
    send_payload(2'b01, 64'h401);
    idle(2);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(bus.VALID_OUT), 64'd0);
    check("t6_rst_data", bus.DATA_OUT, 64'd0);
    check("t6_rst_ctrl", 64'(bus.CTRL_OUT), 64'd0);
    check("t6_rst_aligned", 64'(bus.ALIGNED), 64'd0);
    check("t6_rst_lane", 64'(bus.LANE_STATUS), 64'd0);
    check("t6_rst_crc_cnt", 64'(bus.CRC_ERR_CNT), 64'd0);
    check("t6_rst_frm_cnt", 64'(bus.FRM_ERR_CNT), 64'd0);
    check("t6_rst_state", 64'(bus.state_dbg), 64'(ST_HUNT));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send_word(2'b01, 64'h402);
    check("t6_post_rst_valid", 64'(bus.VALID_OUT), 64'd0);

    // 6d: counter saturation on the 5-word, 4-bit-counter instance
    bus2.LOCKED_IN = 1'b1;
    send_word2(2'b10, SYNC);
    send_word2(2'b10, SCR);
    send_word2(2'b10, SKIP);
    send_word2(2'b01, 64'h55);
    check("t6_len5_valid", 64'(bus2.VALID_OUT), 64'd1);
    check("t6_len5_data", bus2.DATA_OUT, 64'h55);
    send_word2(2'b10, {6'b011001, 24'h0, 2'b11, ~crc_upd(crc_upd(crc_upd(crc_upd(crc_upd(
               32'hFFFF_FFFF, SYNC), SCR), SKIP), 64'h55), {6'b011001, 24'h0, 2'b11, 32'h0})});
    check("t6_len5_aligned", 64'(bus2.ALIGNED), 64'd1);
    check("t6_len5_crc_ok", 64'(bus2.CRC_ERROR), 64'd0);
    for (int i = 0; i < 14; i++) send_frame5(64'(i), 1'b1);
    check("t6_cnt_14", 64'(bus2.CRC_ERR_CNT), 64'd14);
    for (int i = 0; i < 5; i++) send_frame5(64'(i + 20), 1'b1);
    check("t6_cnt_sat", 64'(bus2.CRC_ERR_CNT), 64'hF);
    check("t6_sat_pulse", 64'(bus2.CRC_ERROR), 64'd1);
    check("t6_sat_frm_cnt", 64'(bus2.FRM_ERR_CNT), 64'd0);

    idle(3);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
